imem_fetch_ctrl: RTL and testbench

IMEM_FETCH_CTRL -- requirements
Module: imem_fetch_ctrl

---
 rtl/imem_fetch_ctrl_pkg.sv | 19 +
 rtl/imem_fetch_ctrl_pc_reg.sv | 38 +++
 rtl/imem_fetch_ctrl.sv | 140 ++++++++++++++
 tb/tb_imem_fetch_ctrl.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/imem_fetch_ctrl_pkg.sv
// Shared definitions for the instruction fetch controller: FSM encoding,
// default NOP word and reset PC, plus the 16-bit sequential PC step.
package imem_fetch_ctrl_pkg;

    typedef enum logic [1:0] {
        S_REQ   = 2'd0,
        S_WAIT  = 2'd1,
        S_DRAIN = 2'd2
    } fetch_state_e;

    localparam logic [15:0] NOP_INSTR_DEF = 16'h0800;
    localparam logic [15:0] RESET_PC_DEF  = 16'h0000;

    // Instructions are 16-bit; the address wraps modulo 2^16.
    function automatic logic [15:0] pc_plus2(input logic [15:0] pc);
        return pc + 16'd2;
    endfunction

endpackage

// File: rtl/imem_fetch_ctrl_pc_reg.sv
// Fetch PC register: load has priority over increment, synchronous active-low reset.
// Single-cycle update; holds its value when neither load nor increment is asserted.
module pc_reg
    import imem_fetch_ctrl_pkg::*;
#(
    parameter logic [15:0] RESET_PC = RESET_PC_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load_i,
    input  logic [15:0] load_pc_i,
    input  logic        inc_i,
    output logic [15:0] pc_o
);

    logic [15:0] pc_q;
    logic [15:0] pc_d;

    always_comb begin
        pc_d = pc_q;
        if (load_i) begin
            pc_d = load_pc_i;
        end else if (inc_i) begin
            pc_d = pc_plus2(pc_q);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc_o = pc_q;

endmodule

// File: rtl/imem_fetch_ctrl.sv
// IF stage fetch controller, one outstanding imem read; IMEM_ALIGN_CHECK_EN flags odd redirect targets.
// One instruction per (mem latency + 1) cycles; stall holds a valid output and suppresses new requests.
module imem_fetch_ctrl
    import imem_fetch_ctrl_pkg::*;
#(
    parameter logic [15:0] RESET_PC  = RESET_PC_DEF,
    parameter logic [15:0] NOP_INSTR = NOP_INSTR_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        redirect,
    input  logic [15:0] redirect_pc,
    output logic        imem_req,
    output logic [15:0] imem_addr,
    input  logic        imem_valid,
    input  logic [15:0] imem_rdata,
    input  logic        imem_err,
    output logic        o_valid,
    output logic [15:0] o_instr,
    output logic [15:0] o_pc,
    output logic [15:0] o_next_pc_basic,
    output logic        err
);

    fetch_state_e state_q, state_d;
    logic [15:0]  pc;
    logic [15:0]  redir_pc_al;
    logic         accept;

    logic         o_valid_q, o_valid_d;
    logic [15:0]  o_instr_q, o_instr_d;
    logic [15:0]  o_pc_q, o_pc_d;
    logic [15:0]  o_next_q, o_next_d;
    logic         err_q, err_d;

    assign redir_pc_al = redirect_pc & 16'hFFFE;

    // A response is only taken in WAIT; anything seen in REQ/DRAIN is stale.
    assign accept = (state_q == S_WAIT) && imem_valid && !redirect;

    pc_reg #(
        .RESET_PC (RESET_PC)
    ) u_pc_reg (
        .clk       (clk),
        .rst       (rst),
        .load_i    (redirect),
        .load_pc_i (redir_pc_al),
        .inc_i     (accept),
        .pc_o      (pc)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= S_REQ;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_REQ: begin
                if (imem_req) begin
                    state_d = redirect ? S_DRAIN : S_WAIT;
                end
            end
            S_WAIT: begin
                if (redirect) begin
                    state_d = imem_valid ? S_REQ : S_DRAIN;
                end else if (imem_valid) begin
                    state_d = S_REQ;
                end
            end
            S_DRAIN: begin
                if (imem_valid) begin
                    state_d = S_REQ;
                end
            end
            default: state_d = S_REQ;
        endcase
    end

    always_comb begin
        imem_req  = rst && (state_q == S_REQ) && !(o_valid_q && stall);
        imem_addr = pc;
    end

    always_comb begin
        o_valid_d = o_valid_q;
        o_instr_d = o_instr_q;
        o_pc_d    = o_pc_q;
        o_next_d  = o_next_q;
        err_d     = err_q;
        if (redirect) begin
            o_valid_d = 1'b0;
            o_instr_d = NOP_INSTR;
        end else if (accept) begin
            o_valid_d = 1'b1;
            o_instr_d = imem_err ? NOP_INSTR : imem_rdata;
            o_pc_d    = pc;
            o_next_d  = pc_plus2(pc);
        end else if (o_valid_q && !stall) begin
            o_valid_d = 1'b0;
        end
        if (accept && imem_err) begin
            err_d = 1'b1;
        end
`ifdef IMEM_ALIGN_CHECK_EN
        if (redirect && redirect_pc[0]) begin
            err_d = 1'b1;
        end
`else
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            o_valid_q <= 1'b0;
            o_instr_q <= NOP_INSTR;
            o_pc_q    <= 16'h0000;
            o_next_q  <= 16'h0000;
            err_q     <= 1'b0;
        end else begin
            o_valid_q <= o_valid_d;
            o_instr_q <= o_instr_d;
            o_pc_q    <= o_pc_d;
            o_next_q  <= o_next_d;
            err_q     <= err_d;
        end
    end

    assign o_valid         = o_valid_q;
    assign o_instr         = o_instr_q;
    assign o_pc            = o_pc_q;
    assign o_next_pc_basic = o_next_q;
    assign err             = err_q;

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Directed bench for imem_fetch_ctrl with hand-computed expectations.
module tb_imem_fetch_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        redirect;
    logic [15:0] redirect_pc;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_valid;
    logic [15:0] imem_rdata;
    logic        imem_err;
    logic        o_valid;
    logic [15:0] o_instr;
    logic [15:0] o_pc;
    logic [15:0] o_next_pc_basic;
    logic        err;

    int checks = 0;
    int passes = 0;

`ifdef IMEM_ALIGN_CHECK_EN
    localparam logic [15:0] EXP_ALIGN_ERR = 16'h0001;
`else
    localparam logic [15:0] EXP_ALIGN_ERR = 16'h0000;
`endif

    always #5 clk = ~clk;

    imem_fetch_ctrl dut (
        .clk             (clk),
        .rst             (rst),
        .stall           (stall),
        .redirect        (redirect),
        .redirect_pc     (redirect_pc),
        .imem_req        (imem_req),
        .imem_addr       (imem_addr),
        .imem_valid      (imem_valid),
        .imem_rdata      (imem_rdata),
        .imem_err        (imem_err),
        .o_valid         (o_valid),
        .o_instr         (o_instr),
        .o_pc            (o_pc),
        .o_next_pc_basic (o_next_pc_basic),
        .err             (err)
    );

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = 16'h0000;
        imem_valid = 1'b0; imem_rdata = 16'h0000; imem_err = 1'b0;
        tick();
        tick();
        chk("rst_valid", {15'b0, o_valid}, 16'h0000);
        chk("rst_instr", o_instr, 16'h0800);
        chk("rst_pc", o_pc, 16'h0000);
        chk("rst_next", o_next_pc_basic, 16'h0000);
        chk("rst_err", {15'b0, err}, 16'h0000);
        chk("rst_req", {15'b0, imem_req}, 16'h0000);

        // Basic streaming, 1-cycle memory latency
        rst = 1'b1;
        #1;
        chk("a_req0", {15'b0, imem_req}, 16'h0001);
        chk("a_addr0", imem_addr, 16'h0000);
        tick();
        imem_valid = 1'b1; imem_rdata = 16'hA001;
        #1;
        chk("a_wait_req", {15'b0, imem_req}, 16'h0000);
        tick();
        imem_valid = 1'b0;
        chk("a_v1", {15'b0, o_valid}, 16'h0001);
        chk("a_instr1", o_instr, 16'hA001);
        chk("a_pc1", o_pc, 16'h0000);
        chk("a_next1", o_next_pc_basic, 16'h0002);
        chk("a_addr1", imem_addr, 16'h0002);
        chk("a_req1", {15'b0, imem_req}, 16'h0001);
        tick();
        chk("a_gap", {15'b0, o_valid}, 16'h0000);
        imem_valid = 1'b1; imem_rdata = 16'hA002;
        tick();
        imem_valid = 1'b0;
        chk("a_v2", {15'b0, o_valid}, 16'h0001);
        chk("a_instr2", o_instr, 16'hA002);
        chk("a_pc2", o_pc, 16'h0002);
        chk("a_next2", o_next_pc_basic, 16'h0004);

        // Stall hold for 5 cycles
        stall = 1'b1;
        #1;
        chk("b_req_hold", {15'b0, imem_req}, 16'h0000);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("b_valid_hold", {15'b0, o_valid}, 16'h0001);
            chk("b_instr_hold", o_instr, 16'hA002);
            chk("b_req_off", {15'b0, imem_req}, 16'h0000);
            chk("b_addr_hold", imem_addr, 16'h0004);
        end
        stall = 1'b0;
        #1;
        chk("b_req_resume", {15'b0, imem_req}, 16'h0001);
        chk("b_addr_resume", imem_addr, 16'h0004);
        tick();
        chk("b_consumed", {15'b0, o_valid}, 16'h0000);

        // Redirect during WAIT, stale response two cycles later
        redirect = 1'b1; redirect_pc = 16'h0040;
        tick();
        redirect = 1'b0;
        chk("c_valid", {15'b0, o_valid}, 16'h0000);
        chk("c_drain_req", {15'b0, imem_req}, 16'h0000);
        tick();
        imem_valid = 1'b1; imem_rdata = 16'hDEAD;
        #1;
        chk("c_drain_req2", {15'b0, imem_req}, 16'h0000);
        tick();
        imem_valid = 1'b0;
        chk("c_stale_dropped", {15'b0, o_valid}, 16'h0000);
        chk("c_req_new", {15'b0, imem_req}, 16'h0001);
        chk("c_addr_new", imem_addr, 16'h0040);

        // Redirect coinciding with a response and stall
        tick();
        imem_valid = 1'b1; imem_rdata = 16'h1111;
        tick();
        imem_valid = 1'b0;
        chk("d_v", {15'b0, o_valid}, 16'h0001);
        chk("d_pc", o_pc, 16'h0040);
        chk("d_instr", o_instr, 16'h1111);
        tick();
        redirect = 1'b1; redirect_pc = 16'h0100;
        imem_valid = 1'b1; imem_rdata = 16'h2222; stall = 1'b1;
        tick();
        redirect = 1'b0; imem_valid = 1'b0; stall = 1'b0;
        chk("d_valid_clr", {15'b0, o_valid}, 16'h0000);
        chk("d_instr_nop", o_instr, 16'h0800);
        chk("d_req", {15'b0, imem_req}, 16'h0001);
        chk("d_addr", imem_addr, 16'h0100);

        // PC wrap at 16'hFFFE
        redirect = 1'b1; redirect_pc = 16'hFFFE;
        tick();
        redirect = 1'b0;
        chk("e_drain_req", {15'b0, imem_req}, 16'h0000);
        imem_valid = 1'b1; imem_rdata = 16'h3333;
        tick();
        imem_valid = 1'b0;
        chk("e_dropped", {15'b0, o_valid}, 16'h0000);
        chk("e_addr", imem_addr, 16'hFFFE);
        tick();
        imem_valid = 1'b1; imem_rdata = 16'h4444;
        tick();
        imem_valid = 1'b0;
        chk("e_v", {15'b0, o_valid}, 16'h0001);
        chk("e_pc", o_pc, 16'hFFFE);
        chk("e_next_wrap", o_next_pc_basic, 16'h0000);
        chk("e_instr", o_instr, 16'h4444);
        chk("e_addr_wrap", imem_addr, 16'h0000);

        // Memory fault response
        tick();
        imem_valid = 1'b1; imem_err = 1'b1; imem_rdata = 16'h5555;
        tick();
        imem_valid = 1'b0; imem_err = 1'b0;
        chk("f_v", {15'b0, o_valid}, 16'h0001);
        chk("f_instr_nop", o_instr, 16'h0800);
        chk("f_pc", o_pc, 16'h0000);
        chk("f_err", {15'b0, err}, 16'h0001);
        tick();
        chk("f_err_sticky", {15'b0, err}, 16'h0001);

        // Reset clears err; stale response ignored; odd redirect target
        rst = 1'b0; imem_valid = 1'b1; imem_rdata = 16'h6666;
        tick();
        chk("g_err_clr", {15'b0, err}, 16'h0000);
        chk("g_valid", {15'b0, o_valid}, 16'h0000);
        chk("g_instr", o_instr, 16'h0800);
        chk("g_req_in_rst", {15'b0, imem_req}, 16'h0000);
        rst = 1'b1; redirect = 1'b1; redirect_pc = 16'h0013;
        #1;
        chk("g_req", {15'b0, imem_req}, 16'h0001);
        chk("g_addr", imem_addr, 16'h0000);
        tick();
        redirect = 1'b0; imem_valid = 1'b0;
        chk("g_stale_ignored", {15'b0, o_valid}, 16'h0000);
        chk("g_align_err", {15'b0, err}, EXP_ALIGN_ERR);
        chk("g_drain_req", {15'b0, imem_req}, 16'h0000);
        imem_valid = 1'b1; imem_rdata = 16'h7777;
        tick();
        imem_valid = 1'b0;
        chk("g_dropped", {15'b0, o_valid}, 16'h0000);
        chk("g_req_al", {15'b0, imem_req}, 16'h0001);
        chk("g_addr_al", imem_addr, 16'h0012);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
